// File: rtl/sub_sequencer_pkg.sv
// Shared types and default geometry for the sub_sequencer add/subtract controller.
package sub_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned SLICE_DEF = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub_sequencer_opnd.sv
// Operand and result register file: captures A / conditioned B, presents the
// slice selected by idx to the adder and writes the returned sum slice back.
module sub_sequencer_opnd
    import sub_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF,
    parameter int unsigned IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_beff,
    input  logic             i_run,
    input  logic [IDXW-1:0]  i_idx,
    input  logic [SLICE-1:0] i_sum,
    output logic [SLICE-1:0] o_slice_a,
    output logic [SLICE-1:0] o_slice_b,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [31:0]      w_base;

    assign w_base = 32'(i_idx) * SLICE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_a <= i_a;
                r_b <= i_beff;
            end
            if (i_run) begin
                r_result[w_base +: SLICE] <= i_sum;
            end
        end
    end

    // Slice buses idle at zero whenever no slice is being stepped.
    always_comb begin
        o_slice_a = '0;
        o_slice_b = '0;
        if (i_run) begin
            o_slice_a = r_a[w_base +: SLICE];
            o_slice_b = r_b[w_base +: SLICE];
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/sub_sequencer.sv
// Multi-cycle add/subtract controller time-sharing an external SLICE-bit adder.
// Optional SUB_SEQUENCER_PERF_EN adds perf_ops / perf_busy counters.
module sub_sequencer
    import sub_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    input  logic [SLICE-1:0] slice_sum,
    input  logic             slice_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_ovf
`ifdef SUB_SEQUENCER_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_busy
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_ovf;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_beff;
    logic             w_cin0;

    assign w_run    = (r_state == RUN);
    assign w_accept = (r_state == IDLE) & req_valid;
    assign w_rsp_hs = (r_state == DONE) & rsp_ready;
    assign w_last   = (r_idx == IDXW'(NSLICE - 1));

    // Subtract is A + ~B + ~borrow.
    assign w_beff = (op_e'(req_op) == OP_SUB) ? ~req_b : req_b;
    assign w_cin0 = (op_e'(req_op) == OP_SUB) ? ~req_cin : req_cin;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= '0;
                r_carry <= w_cin0;
                r_amsb  <= req_a[WIDTH-1];
                r_bmsb  <= w_beff[WIDTH-1];
            end
            if (w_run) begin
                r_carry <= slice_cout;
                r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
                // Overflow resolved on the top slice, when the sign bit appears.
                if (w_last) begin
                    r_ovf <= (r_amsb == r_bmsb) & (slice_sum[SLICE-1] != r_amsb);
                end
            end
        end
    end

    sub_sequencer_opnd #(
        .WIDTH (WIDTH),
        .SLICE (SLICE),
        .IDXW  (IDXW)
    ) u_opnd (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_a       (req_a),
        .i_beff    (w_beff),
        .i_run     (w_run),
        .i_idx     (r_idx),
        .i_sum     (slice_sum),
        .o_slice_a (slice_a),
        .o_slice_b (slice_b),
        .o_result  (rsp_result)
    );

    assign slice_cin = w_run ? r_carry : 1'b0;
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == DONE);
    assign rsp_cout  = r_carry;
    assign rsp_ovf   = r_ovf;

`ifdef SUB_SEQUENCER_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_ops  <= '0;
            r_perf_busy <= '0;
        end else begin
            if (w_rsp_hs)          r_perf_ops  <= r_perf_ops + 32'd1;
            if (r_state != IDLE)   r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_ops  = r_perf_ops;
    assign perf_busy = r_perf_busy;
`else
    logic w_unused;
    assign w_unused = w_rsp_hs;
`endif

endmodule

// File: doc/sub_sequencer.md
Name: sub_sequencer

Overview:
- Multi-cycle add/subtract controller that time-shares one SLICE-bit adder slice, external to this block, across a WIDTH-bit operation.
- Per operation: captures operands, conditions B for subtraction (ones-complement plus carry-in), and steps slices LSB-first through the adder with a registered carry chain.
- Assembles the result and flags, then returns them over a valid/ready response port.
- Sits between the requesting datapath and the shared adder slice.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SLICE.
- SLICE, 8, width of the shared adder slice.
- NSLICE, WIDTH/SLICE, derived; number of RUN cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  1  0 = add, 1 = subtract.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in (add) or borrow-in (subtract).
- slice_a  out  SLICE  current A slice to the adder.
- slice_b  out  SLICE  current conditioned B slice to the adder.
- slice_cin  out  1  carry into the current slice.
- slice_sum  in  SLICE  adder sum, combinational from the slice_* outputs.
- slice_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  WIDTH  A+B+cin, or A-B-bin.
- rsp_cout  out  1  add: carry-out; subtract: 1 = no borrow.
- rsp_ovf  out  1  signed overflow.

Behaviour:
- Reset: on a clk edge with rst_n=0, state becomes IDLE and all registers clear. After that edge, rsp_valid, rsp_result, rsp_cout, rsp_ovf, slice_a, slice_b and slice_cin are 0, and req_ready is 1. Reset wins over any handshake on the same edge.
- States:
  - IDLE -> RUN on req_valid & req_ready.
  - RUN -> DONE after NSLICE RUN cycles.
  - DONE -> IDLE on rsp_valid & rsp_ready.
- req_ready = (state==IDLE). rsp_valid = (state==DONE). Neither depends combinationally on req_valid or rsp_ready.
- Accept edge E0 registers:
  - A.
  - Beff = req_op ? ~req_b : req_b.
  - carry = req_op ? ~req_cin : req_cin.
  - idx = 0.
  - op, A MSB and Beff MSB, kept for overflow.
- RUN cycle k (0..NSLICE-1):
  - slice_a = A[k*SLICE +: SLICE], slice_b = Beff[same], slice_cin = carry.
  - On the edge: result[k*SLICE +: SLICE] <= slice_sum, carry <= slice_cout, idx++.
  - Outside RUN, slice_* outputs are 0.
- Latency: the last RUN edge is E(NSLICE). rsp_valid is first high in the cycle after E(NSLICE), i.e. NSLICE+1 cycles after the accept cycle.
- Completion:
  - rsp_cout = final carry.
  - rsp_ovf = (Amsb==Beffmsb) & (result MSB != Amsb).
- Backpressure: in DONE, all rsp_* outputs hold stable until rsp_ready. No new request is accepted until the state returns to IDLE.
- Minimum issue interval: NSLICE+2 cycles, with rsp_ready tied high and back-to-back requests.
- Reset asserted mid-RUN or in DONE aborts the operation. No response is produced for it.
- Inputs req_a, req_b, req_op and req_cin are sampled only at the accept edge. Changes afterwards have no effect.
- Arithmetic is modulo 2^WIDTH. slice_cout from slice NSLICE-1 is the only carry exported.

Optional Feature:
- Macro: SUB_SEQUENCER_PERF_EN.
- Defined: adds two outputs.
  - perf_ops (32): increments on each response handshake.
  - perf_busy (32): increments on each cycle with state != IDLE.
  - Both clear on reset and wrap at 2^32.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package sub_sequencer_pkg:
  - op_e {OP_ADD=0, OP_SUB=1}.
  - state_e {IDLE, RUN, DONE}.
  - Default SLICE and WIDTH localparams.
- One sub-module, sub_sequencer_opnd: operand/result register file with slice select and write-back, indexed by idx.
- The FSM and flag logic stay in the top.

Test Plan:
- Subtract, A=5, B=3, bin=0 -> result 2, rsp_cout=1, rsp_ovf=0. rsp_valid rises exactly 9 cycles after the accept cycle (WIDTH=64, SLICE=8).
- Subtract, A=0, B=1 -> result 0xFFFF_FFFF_FFFF_FFFF, rsp_cout=0 (borrow), rsp_ovf=0.
- Add, A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result 0x8000_0000_0000_0000, rsp_ovf=1, rsp_cout=0.
- Add with carry across slices, A=0x00FF, B=0x0001, cin=1 -> result 0x0101. During the RUN cycle with k=1, slice_cin=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* outputs stable and req_ready=0 throughout. Release -> req_ready=1 on the next cycle.
- Reset: drop rst_n during RUN at k=3 -> the next cycle shows IDLE, rsp_valid=0, result=0, and no response. A new request then completes correctly.
